// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the skid-stage state encoding, the default widths used at each core
// stage boundary, the control-field bit positions shared by the decoder and
// the stages, and a saturating-increment helper for the optional counters.
package pipe_pkg;

  // State is the concatenation {skid_valid, main_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } pipe_state_e;

  // Default widths per stage boundary.
  localparam int IFID_DATA_W  = 64;   // pc + instruction word
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 128;  // pc + two operands + immediate
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 96;   // result + store data + pc
  localparam int EXMEM_CTRL_W = 12;
  localparam int MEMWB_DATA_W = 64;   // load/alu result + pc
  localparam int MEMWB_CTRL_W = 8;

  // Control-field bit positions.
  localparam int CTRL_WE_BIT    = 0;
  localparam int CTRL_LOAD_BIT  = 1;
  localparam int CTRL_STORE_BIT = 2;
  localparam int CTRL_RD_LSB    = 3;
  localparam int CTRL_RD_MSB    = 7;
  localparam int CTRL_TYPE_LSB  = 8;
  localparam int CTRL_TYPE_MSB  = 9;
  localparam int CTRL_MUX_LSB   = 10;
  localparam int CTRL_MUX_MSB   = 11;

  localparam int PERF_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control vector and payload register.
// Latency: 1 cycle from load to visible contents.
// Backpressure: none internally; the parent decides when to load or clear.
//
// Ports: clk, rst (async active-low), flush (kill entry, highest priority),
//   load/ld_ctrl/ld_data (capture a new entry), clr (drop the entry),
//   valid/ctrl/data (current contents).
// ctrl is forced to zero whenever the entry is invalid so a bubble never
// carries stray write-enables; data is left alone on clear/flush.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

  // Payload has no bubble semantics; it only changes on a real load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (load && !flush) begin
      data <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake and flush.
// Latency: 1 cycle in->out when empty; strict FIFO order.
// Backpressure: SKID=1 two-entry skid, registered in_ready; SKID=0 single entry, in_ready = out_ready || !out_valid.
//
// Ports: clk, rst (async active-low), flush (sync kill, drops same-cycle input),
//   in_valid/in_ready/in_ctrl/in_data (upstream), out_valid/out_ready/out_ctrl/out_data (downstream).
// Optional macro PIPE_STAGE_PERF_EN adds stall_cnt and bubble_cnt (32-bit saturating).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              accept;
  logic              drain;

  // Flush swallows whatever upstream offers in the same cycle.
  assign accept = in_valid && in_ready && !flush;
  assign drain  = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      pipe_state_e       state;
      logic              main_load;
      logic              main_clr;
      logic              main_from_skid;
      logic              skid_load;
      logic              skid_clr;
      logic [CTRL_W-1:0] main_ld_ctrl;
      logic [DATA_W-1:0] main_ld_data;

      assign state = pipe_state_e'({skid_valid, main_valid});

      // skid_valid is a flop, so in_ready carries no combinational path
      // from out_ready; it is low exactly in FULL.
      assign in_ready = !skid_valid;

      always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        case (state)
          ST_EMPTY: begin
            main_load = accept;
          end
          ST_BUSY: begin
            if (accept && !drain) begin
              skid_load = 1'b1;
            end else if (accept && drain) begin
              main_load = 1'b1;
            end else if (drain) begin
              main_clr = 1'b1;
            end
          end
          ST_FULL: begin
            // Skid entry is older than anything upstream, so it refills main.
            if (drain) begin
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clr       = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end

      assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
      assign main_ld_data = main_from_skid ? skid_data : in_data;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (main_load),
        .clr     (main_clr),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
      );

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (skid_load),
        .clr     (skid_clr),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );
    end else begin : g_noskid
      logic main_clr;

      assign in_ready = out_ready || !main_valid;
      assign main_clr = drain && !accept;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (accept),
        .clr     (main_clr),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
      );
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] bubble_q;

  // Survive flush on purpose: they measure the whole run, not one window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        stall_q <= sat_inc(stall_q);
      end
      if (!main_valid) begin
        bubble_q <= sat_inc(bubble_q);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance.
// Latency: n/a.
// Backpressure: driven directly from the stimulus.
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int CW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   a_stall, a_bubble, b_stall, b_bubble;
`endif

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall), .bubble_cnt(a_bubble)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall), .bubble_cnt(b_bubble)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic          erdy;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [CW-1:0] ic, logic [DW-1:0] id, logic ordy, logic fl,
                              logic ev, logic [CW-1:0] ec, logic [DW-1:0] ed, logic erdy);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ed = ed; v.erdy = erdy;
    return v;
  endfunction

  localparam logic [CW-1:0] CA = 12'h1A1, CB = 12'h2B2, CC = 12'h3C3, CP = 12'h414;
  localparam logic [CW-1:0] CQ = 12'h525, CD = 12'h6D6, CE = 12'h7E7, CF = 12'h8F8;
  localparam logic [DW-1:0] DA = {16{8'hA1}}, DB = {16{8'hB2}}, DC = {16{8'hC3}}, DP = {16{8'h44}};
  localparam logic [DW-1:0] DQ = {16{8'h55}}, DD = {16{8'hD6}}, DE = {16{8'hE7}}, DF = {16{8'hF8}};

  vec_t tbl [13];
  int   sent, rcv;
  logic mv, rdy_exp, ordy, drn, acc;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Each row: inputs for one cycle, and outputs expected during that cycle.
    //          iv  ic  id  ordy fl   ev  ec  ed  erdy
    tbl[0]  = mk(1, CA, DA, 0, 0,   0, 0,  '0, 1);
    tbl[1]  = mk(1, CB, DB, 0, 0,   1, CA, DA, 1);
    tbl[2]  = mk(1, CC, DC, 0, 0,   1, CA, DA, 0);
    tbl[3]  = mk(1, CC, DC, 1, 0,   1, CA, DA, 0);
    tbl[4]  = mk(1, CC, DC, 1, 0,   1, CB, DB, 1);
    tbl[5]  = mk(0, 0,  '0, 1, 0,   1, CC, DC, 1);
    tbl[6]  = mk(1, CP, DP, 0, 0,   0, 0,  '0, 1);
    tbl[7]  = mk(1, CQ, DQ, 0, 0,   1, CP, DP, 1);
    tbl[8]  = mk(1, CD, DD, 0, 1,   1, CP, DP, 0);
    tbl[9]  = mk(1, CE, DE, 1, 0,   0, 0,  '0, 1);
    tbl[10] = mk(0, 0,  '0, 1, 0,   1, CE, DE, 1);
    tbl[11] = mk(1, CF, DF, 1, 1,   0, 0,  '0, 1);
    tbl[12] = mk(0, 0,  '0, 1, 0,   0, 0,  '0, 1);

    rst = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset asserted mid-stream with both stages holding entries.
    a_in_valid = 1; a_in_ctrl = 12'hABC; a_in_data = DA;
    b_in_valid = 1; b_in_ctrl = 12'hABC; b_in_data = DA;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst a out_valid", a_out_valid, 1'b0);
    check("rst a out_ctrl", a_out_ctrl, '0);
    check("rst a out_data", a_out_data, '0);
    check("rst a in_ready", a_in_ready, 1'b1);
    check("rst b out_valid", b_out_valid, 1'b0);
    check("rst b out_ctrl", b_out_ctrl, '0);
    check("rst b out_data", b_out_data, '0);
    @(posedge clk); #1;
    check("rst held a out_valid", a_out_valid, 1'b0);
    check("rst held a out_ctrl", a_out_ctrl, '0);
    a_in_valid = 0; b_in_valid = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("post-rst a in_ready", a_in_ready, 1'b1);
    check("post-rst b in_ready", b_in_ready, 1'b1);
    check("post-rst a out_valid", a_out_valid, 1'b0);
    @(posedge clk); #1;

    // Back-to-back streaming through the skid stage.
    for (int i = 0; i < 10; i++) begin
      a_in_valid = (i < 8); a_in_data = DW'(i + 1); a_in_ctrl = CW'(i + 1);
      a_out_ready = 1; a_flush = 0;
      @(negedge clk);
      check($sformatf("stream%0d in_ready", i), a_in_ready, 1'b1);
      if (i >= 1 && i <= 8) begin
        check($sformatf("stream%0d out_valid", i), a_out_valid, 1'b1);
        check($sformatf("stream%0d out_data", i), a_out_data, DW'(i));
        check($sformatf("stream%0d out_ctrl", i), a_out_ctrl, CW'(i));
      end else begin
        check($sformatf("stream%0d out_valid", i), a_out_valid, 1'b0);
      end
      @(posedge clk); #1;
    end

    // Backpressure, skid fill/drain and flush corner cases.
    for (int i = 0; i < 13; i++) begin
      a_in_valid = tbl[i].iv; a_in_ctrl = tbl[i].ic; a_in_data = tbl[i].id;
      a_out_ready = tbl[i].ordy; a_flush = tbl[i].fl;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), a_out_valid, tbl[i].ev);
      check($sformatf("vec%0d out_ctrl", i), a_out_ctrl, tbl[i].ec);
      check($sformatf("vec%0d in_ready", i), a_in_ready, tbl[i].erdy);
      if (tbl[i].ev) check($sformatf("vec%0d out_data", i), a_out_data, tbl[i].ed);
      @(posedge clk); #1;
    end
    a_in_valid = 0; a_flush = 0;

    // SKID=0: out_ready toggles every cycle, 16 entries offered continuously.
    sent = 0; rcv = 0; mv = 0;
    for (int cyc = 0; cyc < 200 && rcv < 16; cyc++) begin
      ordy = cyc[0];
      b_out_ready = ordy;
      b_in_valid  = (sent < 16);
      b_in_data   = DW'(200 + sent);
      b_in_ctrl   = CW'(sent + 1);
      @(negedge clk);
      rdy_exp = ordy || !mv;
      check($sformatf("skid0 c%0d in_ready", cyc), b_in_ready, rdy_exp);
      check($sformatf("skid0 c%0d out_valid", cyc), b_out_valid, mv);
      if (mv) begin
        check($sformatf("skid0 c%0d out_data", cyc), b_out_data, DW'(200 + rcv));
        check($sformatf("skid0 c%0d out_ctrl", cyc), b_out_ctrl, CW'(rcv + 1));
      end else begin
        check($sformatf("skid0 c%0d bubble ctrl", cyc), b_out_ctrl, '0);
      end
      drn = mv && ordy;
      acc = b_in_valid && rdy_exp;
      if (drn) rcv++;
      if (acc) sent++;
      if (acc) mv = 1'b1;
      else if (drn) mv = 1'b0;
      @(posedge clk); #1;
    end
    check("skid0 delivered", DW'(rcv), DW'(16));
    b_in_valid = 0;

`ifdef PIPE_STAGE_PERF_EN
    a_in_valid = 0; a_out_ready = 0;
    rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    // Two accepts fill the stage, then five stalled cycles.
    a_in_valid = 1; a_in_data = DA; a_in_ctrl = CA;
    repeat (7) begin @(posedge clk); #1; end
    a_in_valid = 0; a_out_ready = 1;
    repeat (5) begin @(posedge clk); #1; end
    check("perf stall_cnt", a_stall, 32'd5);
    check("perf bubble_cnt>=3", (a_bubble >= 32'd3), 1'b1);
    a_in_valid = 1; a_out_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    force dut_a.stall_q = 32'hFFFF_FFFD;
    #1 release dut_a.stall_q;
    repeat (3) @(posedge clk);
    #1;
    check("perf stall_cnt saturate", a_stall, 32'hFFFF_FFFF);
    a_in_valid = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One instance carries one flat data vector plus a separate control vector between two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer, flush-to-bubble and async reset.
- Sits between any two core stages. The hazard unit drives flush; downstream backpressure drives out_ready.

Parameters:
- DATA_W, 128: width of the payload (operands, results, immediates, PCs), not cleared on flush.
- CTRL_W, 12: width of the control vector (we, rd, store, load, type, mux selects); zeroed whenever the entry is invalid.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control vector.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control to next stage.
- out_data  out  DATA_W  payload to next stage.

Behaviour:
- Reset (rst=0, async), all regardless of clk:
  - out_valid=0, out_ctrl=0, out_data=0.
  - Skid entry cleared.
  - in_ready=1 (SKID=1); in SKID=0 it follows its equation.
- Handshake: transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
- in_valid may drop without a transfer; data need not be held by upstream.
- Latency: 1 cycle in to out when the stage is empty. Strict FIFO order.
- SKID=1 state machine, encoded from two valid bits (main, skid):
  - EMPTY: main=0, skid=0. Accept → BUSY.
  - BUSY: main=1, skid=0.
    - Accept without drain → FULL; the new entry goes to skid.
    - Drain without accept → EMPTY.
    - Accept and drain together → BUSY, main loaded with input.
  - FULL: main=1, skid=1. in_ready=0.
    - Drain → BUSY; skid moves to main the same edge.
    - No accept possible in FULL.
  - in_ready is registered: 1 in EMPTY/BUSY, 0 in FULL.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - Main loads on accept, clears valid on drain without accept.
- Flush (synchronous, highest priority):
  - Next edge: main and skid valid=0, out_ctrl=0, skid ctrl=0. Data regs hold their value.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - in_ready=1 the cycle after.
- Bubble invariant: out_valid=0 implies out_ctrl=0, at all times including after reset and flush.
- Stalled output (out_valid=1, out_ready=0): out_ctrl and out_data stay stable until transfer.
- Reset asserted mid-transfer: entries lost; no partial state survives.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds ports stall_cnt (out, 32) and bubble_cnt (out, 32).
  - stall_cnt increments each cycle with in_valid=1 && in_ready=0.
  - bubble_cnt increments each cycle with out_valid=0.
  - Both saturate at 32'hFFFF_FFFF, reset to 0 on rst, and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - state encoding constants ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b11.
  - default widths for each stage boundary (IFID_DATA_W, IDEX_CTRL_W, EXMEM_DATA_W, EXMEM_CTRL_W, ...).
  - control-field bit positions shared by decoder and stages.
- One sub-module, pipe_slot: a single valid+ctrl+data register with load, clear-valid and flush inputs. It is instantiated twice (main, skid) when SKID=1 and once when SKID=0.

Test Plan:
- Reset: hold rst=0 mid-stream with in_valid=1, in_ctrl=12'hABC → out_valid=0, out_ctrl=0, out_data=0 asynchronously. After release, in_ready=1.
- Streaming, out_ready=1: send data 1..8 back-to-back → out_data 1..8 in order, each 1 cycle later, no bubbles, in_ready constantly 1.
- Backpressure, SKID=1: out_ready=0 while sending A, B, C → A held on output, B in skid, in_ready=0 after B, C not accepted. Raise out_ready → A, B, C delivered in order, no loss or duplication.
- Flush in FULL with in_valid=1 (entry D) → next cycle out_valid=0, out_ctrl=0, D dropped, in_ready=1. Next entry E exits with 1-cycle latency.
- SKID=0, out_ready toggling every cycle over 16 entries → in_ready equals out_ready||!out_valid each cycle; all 16 delivered in order.
- PIPE_STAGE_PERF_EN: 5 stalled cycles then 3 empty cycles → stall_cnt=5, bubble_cnt≥3. Preload near-max via long run or force → stall_cnt saturates at FFFF_FFFF.
